io_marker_timer: RTL and testbench

Wishbone slave in the user project area that firmware writes progress markers to. It drives the markers onto the upper user GPIOs (checkbits on mprj_io[23:16], result byte on mprj_io[31:24]) for the Caravel testbench. It also measures, in hardware, the clock cycles between the start marker (0xA5) and the stop marker (0x5A), so FIR latency is readable on-chip as well as in simulation.

---
 rtl/io_marker_pkg.sv | 29 ++
 rtl/marker_cycle_counter.sv | 52 +++++
 rtl/io_marker_timer.sv | 198 +++++++++++++++++++
 tb/tb_io_marker_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_marker_pkg.sv
// io_marker_pkg
// Shared constants and types for the io_marker_timer slice.
// Contents:
//   - register byte offsets inside the 16-byte Wishbone window
//   - STATUS bit indices
//   - timer state enum (IDLE / RUN / DONE)
//   - default base address and marker values
package io_marker_pkg;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
  localparam logic [7:0]  DEF_MARK_START = 8'hA5;
  localparam logic [7:0]  DEF_MARK_STOP  = 8'h5A;

  localparam logic [3:0] OFS_MARK   = 4'h0;
  localparam logic [3:0] OFS_CYCLES = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_RSVD   = 4'hC;

  localparam int STAT_RUNNING = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } marker_state_t;

endpackage

// File: rtl/marker_cycle_counter.sv
// marker_cycle_counter
// Saturating cycle counter used to time the span between start and stop
// markers. Clear has priority over everything and also drops the overflow
// flag; once the count reaches all-ones further enables hold the value and
// set the sticky overflow flag.
// Ports:
//   clock      in   clock
//   RSTB       in   asynchronous active-low reset
//   clear      in   zero the count and the overflow flag
//   enable     in   count this cycle
//   clear_ovf  in   drop the overflow flag
//   count      out  current count, CNT_W bits
//   overflow   out  sticky saturation flag
module marker_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic             clear,
  input  logic             enable,
  input  logic             clear_ovf,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A clear request wins over an increment so a restart always begins at 0.
  // An overflow clear landing on the same edge as a saturating increment
  // leaves the flag cleared; it re-arms on the next saturated cycle.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enable) begin
        if (count == CNT_MAX) begin
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_marker_timer.sv
// io_marker_timer
// Wishbone slave that firmware writes progress markers into. The MARK
// register is mirrored onto mprj_io[31:16] (checkbits low byte, result high
// byte) and a hardware timer measures the cycles between the start and stop
// markers.
// Register map (byte offset from BASE_ADDR):
//   0x0 MARK    RW  [7:0] checkbits, [15:8] result
//   0x4 CYCLES  RO  zero-extended cycle count
//   0x8 STATUS  RO  [0] running, [1] done, [2] overflow; W1C on [1], [2]
//   0xC         reads 0, writes ignored
// Ports:
//   clock, RSTB              clock and asynchronous active-low reset
//   wbs_cyc_i .. wbs_dat_i   Wishbone classic slave inputs
//   wbs_ack_o, wbs_dat_o     single-cycle ack and read data (0 when idle)
//   io_out, io_oeb           user GPIO data and output-enable-bar
//   irq_o                    done pulse
// Build option:
//   MARKER_IRQ_EN  when defined irq_o pulses one cycle on the edge after the
//                  RUN->DONE transition; otherwise irq_o is tied low.
module io_marker_timer
  import io_marker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [7:0]  MARK_START = DEF_MARK_START,
  parameter logic [7:0]  MARK_STOP  = DEF_MARK_STOP,
  parameter int          CNT_W      = 32
) (
  input  logic        clock,
  input  logic        RSTB,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq_o
);

  marker_state_t    state;
  marker_state_t    state_next;
  logic [15:0]      mark_reg;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [31:0]      rdata;
  logic [3:0]       offset;

  logic hit;
  logic access;
  logic wr_commit;
  logic rd_commit;
  logic mark_wr;
  logic status_wr;
  logic start_evt;
  logic stop_evt;
  logic done_clr;
  logic ovf_clr;

  // Bus decode. An access is taken only while ack is low, which makes ack a
  // one-cycle pulse and every write commit on the edge that raises ack.
  assign hit       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access    = hit && !wbs_ack_o;
  assign wr_commit = access && wbs_we_i;
  assign rd_commit = access && !wbs_we_i;
  assign offset    = {wbs_adr_i[3:2], 2'b00};
  assign mark_wr   = wr_commit && (offset == OFS_MARK);
  assign status_wr = wr_commit && (offset == OFS_STATUS);

  // Marker and W1C events only fire when byte lane 0 is enabled.
  assign start_evt = mark_wr && wbs_sel_i[0] && (wbs_dat_i[7:0] == MARK_START);
  assign stop_evt  = mark_wr && wbs_sel_i[0] && (wbs_dat_i[7:0] == MARK_STOP);
  assign done_clr  = status_wr && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];
  assign ovf_clr   = status_wr && wbs_sel_i[0] && wbs_dat_i[STAT_OVF];

  // Wishbone acknowledge and registered read data.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd_commit ? rdata : 32'h0;
    end
  end

  // Read mux; CYCLES returns the live counter value.
  always_comb begin
    rdata = '0;
    case (offset)
      OFS_MARK:   rdata[15:0] = mark_reg;
      OFS_CYCLES: rdata[CNT_W-1:0] = count;
      OFS_STATUS: begin
        rdata[STAT_RUNNING] = (state == ST_RUN);
        rdata[STAT_DONE]    = (state == ST_DONE);
        rdata[STAT_OVF]     = overflow;
      end
      default:    rdata = '0;
    endcase
  end

  // MARK register with per-byte lane enables; it drives the GPIOs directly.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      mark_reg <= '0;
    end else if (mark_wr) begin
      if (wbs_sel_i[0]) mark_reg[7:0]  <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) mark_reg[15:8] <= wbs_dat_i[15:8];
    end
  end

  assign io_out = mark_reg;
  assign io_oeb = 16'h0000;

  // Timer state register.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and counter control. The counter stays enabled on the stop
  // edge itself so the result includes the stop commit edge.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_evt) begin
          state_next = ST_RUN;
          cnt_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_enable = 1'b1;
        if (start_evt) begin
          cnt_clear = 1'b1;
        end else if (stop_evt) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_evt) begin
          state_next = ST_RUN;
          cnt_clear  = 1'b1;
        end else if (done_clr) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  marker_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock     (clock),
    .RSTB      (RSTB),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .clear_ovf (ovf_clr),
    .count     (count),
    .overflow  (overflow)
  );

`ifdef MARKER_IRQ_EN
  logic stop_seen;
  logic irq_q;

  // stop_seen marks the RUN->DONE edge; irq_q delays it by one more edge.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      stop_seen <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      stop_seen <= (state == ST_RUN) && (state_next == ST_DONE);
      irq_q     <= stop_seen;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Upper byte lanes, upper data bits and the byte-address bits carry no
  // information for this register set.
  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_io_marker_timer.sv
// tb_io_marker_timer
// Directed bench for io_marker_timer built with CNT_W=16 so saturation is
// reachable. Expected values are hand-derived from the marker timing rules.
// Honours MARKER_IRQ_EN to pick the expected irq_o behaviour.
module tb_io_marker_timer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        RSTB  = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i  = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        irq_o;

  int total_checks = 0;
  int pass_checks  = 0;

  logic irq_at_ack;
  logic irq_after;
  logic [31:0] rd_val;

`ifdef MARKER_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  always #5 clock = ~clock;

  io_marker_timer #(
    .CNT_W(16)
  ) dut (
    .clock     (clock),
    .RSTB      (RSTB),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) begin
      pass_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive idle bus values.
  task automatic bus_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = 32'h0;
  endtask

  // One write; commits on the first edge. Checks ack is high for exactly one
  // cycle and records irq_o after the commit edge and the edge after it.
  task automatic wb_write(input logic [3:0] ofs, input logic [31:0] data, input logic [3:0] sel);
    logic a1, a2;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = BASE | {28'h0, ofs};
    wbs_dat_i = data;
    wbs_sel_i = sel;
    @(posedge clock); #1;
    a1 = wbs_ack_o;
    irq_at_ack = irq_o;
    bus_idle();
    @(posedge clock); #1;
    a2 = wbs_ack_o;
    irq_after = irq_o;
    checkOutput("wr_ack_pulse", {30'h0, a1, a2}, 32'h2);
  endtask

  // One read; returns data sampled while ack is high and checks the ack pulse.
  task automatic wb_read(input logic [3:0] ofs, output logic [31:0] data);
    logic a1, a2;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE | {28'h0, ofs};
    wbs_sel_i = 4'hF;
    @(posedge clock); #1;
    a1 = wbs_ack_o;
    data = wbs_dat_o;
    bus_idle();
    @(posedge clock); #1;
    a2 = wbs_ack_o;
    checkOutput("rd_ack_pulse", {30'h0, a1, a2}, 32'h2);
  endtask

  // Read a register and compare it against a hand-computed value.
  task automatic read_check(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(ofs, v);
    checkOutput(tag, v, exp);
  endtask

  initial begin
    // Reset state
    #1;
    checkOutput("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    checkOutput("rst_dat", wbs_dat_o, 32'h0);
    checkOutput("rst_io_out", {16'h0, io_out}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq_o}, 32'h0);
    #20 RSTB = 1'b1;
    wait_edges(1);
    read_check("rst_mark", 4'h0, 32'h0);
    read_check("rst_cycles", 4'h4, 32'h0);
    read_check("rst_status", 4'h8, 32'h0);
    wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    read_check("rsvd_read", 4'hC, 32'h0);
    checkOutput("rst_io_oeb", {16'h0, io_oeb}, 32'h0);
    checkOutput("idle_dat_zero", wbs_dat_o, 32'h0);

    // Start then stop ten edges later (commit to commit)
    $display("[TB] basic start/stop");
    wb_write(4'h0, 32'h0000_00A5, 4'h3);
    checkOutput("io_out_start", {16'h0, io_out}, 32'h00A5);
    wait_edges(8);
    wb_write(4'h0, 32'h0000_2A5A, 4'h3);
    checkOutput("irq_at_stop_edge", {31'h0, irq_at_ack}, 32'h0);
    checkOutput("irq_pulse", {31'h0, irq_after}, {31'h0, IRQ_EXP});
    wait_edges(1);
    checkOutput("irq_one_cycle", {31'h0, irq_o}, 32'h0);
    read_check("cycles_10", 4'h4, 32'd10);
    read_check("status_done", 4'h8, 32'h2);
    checkOutput("io_out_stop", {16'h0, io_out}, 32'h2A5A);
    read_check("mark_readback", 4'h0, 32'h0000_2A5A);
    wb_write(4'h8, 32'h0000_0002, 4'h1);
    read_check("status_after_w1c", 4'h8, 32'h0);
    read_check("cycles_kept", 4'h4, 32'd10);

    // Restart, other marker value, stop: 7 edges from the restart
    $display("[TB] restart");
    wb_write(4'h0, 32'h0000_00A5, 4'h3);
    wait_edges(3);
    wb_write(4'h0, 32'h0000_00A5, 4'h3);
    wb_write(4'h0, 32'h0000_1133, 4'h3);
    checkOutput("io_out_other", {16'h0, io_out}, 32'h1133);
    wait_edges(3);
    wb_write(4'h0, 32'h0000_005A, 4'h3);
    read_check("cycles_7", 4'h4, 32'd7);
    read_check("status_done2", 4'h8, 32'h2);

    // sel[0]=0: only the result byte changes, no state change
    wb_write(4'h0, 32'h0000_77A5, 4'h2);
    checkOutput("io_out_lane1", {16'h0, io_out}, 32'h775A);
    read_check("status_sel0_off", 4'h8, 32'h2);
    read_check("cycles_sel0_off", 4'h4, 32'd7);
    wb_write(4'h8, 32'h0000_0002, 4'h1);
    read_check("status_idle", 4'h8, 32'h0);

    // Reset in the middle of RUN and during an acked read
    $display("[TB] reset mid-run");
    wb_write(4'h0, 32'h0000_00A5, 4'h3);
    read_check("status_running", 4'h8, 32'h1);
    wait_edges(46);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE | 32'h4;
    wbs_sel_i = 4'hF;
    @(posedge clock); #1;
    checkOutput("mid_read_ack", {31'h0, wbs_ack_o}, 32'h1);
    RSTB = 1'b0;
    #1;
    checkOutput("async_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    checkOutput("async_rst_dat", wbs_dat_o, 32'h0);
    checkOutput("async_rst_io", {16'h0, io_out}, 32'h0);
    checkOutput("async_rst_irq", {31'h0, irq_o}, 32'h0);
    bus_idle();
    #3 RSTB = 1'b1;
    wait_edges(1);
    checkOutput("post_rst_no_ack", {31'h0, wbs_ack_o}, 32'h0);
    read_check("post_rst_cycles", 4'h4, 32'h0);
    read_check("post_rst_status", 4'h8, 32'h0);

    // Saturation with a 16-bit counter
    $display("[TB] saturation");
    wb_write(4'h0, 32'h0000_00A5, 4'h1);
    wait_edges(70000);
    wb_write(4'h0, 32'h0000_005A, 4'h1);
    read_check("cycles_sat", 4'h4, 32'h0000_FFFF);
    read_check("status_ovf", 4'h8, 32'h6);
    wb_write(4'h8, 32'h0000_0006, 4'h1);
    read_check("status_cleared", 4'h8, 32'h0);
    read_check("cycles_after_clr", 4'h4, 32'h0000_FFFF);
    checkOutput("irq_quiet_end", {31'h0, irq_o}, 32'h0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
